// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the loader state enum, the header field positions, the per-memory
// word limit and the header validity check used by program_loader.
package loader_pkg;

    // Largest image either RAM can take, in words.
    localparam int MAX_WORDS = 2048;

    // Word counters must hold MAX_WORDS itself, so they are one bit wider
    // than the default 11-bit address.
    localparam int CNT_W = 12;

    // Header word layout: IM count in [27:16], DM count in [11:0].
    localparam int HDR_N_LSB = 16;
    localparam int HDR_N_MSB = 27;
    localparam int HDR_M_LSB = 0;
    localparam int HDR_M_MSB = 11;

    // ST_CHECK is only reachable when the trailing checksum word is enabled.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_LOAD_IM = 3'd2,
        ST_LOAD_DM = 3'd3,
        ST_CHECK   = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    // An image needs at least one instruction, and neither image may exceed
    // the RAM depth; this also guarantees the address counter never wraps.
    function automatic logic hdr_bad(input logic [CNT_W-1:0] n,
                                     input logic [CNT_W-1:0] m);
        return (n == '0) ||
               (n > CNT_W'(MAX_WORDS)) ||
               (m > CNT_W'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: running XOR over the header and payload words of a session.
// Latency: accumulates on the edge the word is accepted; match_o is combinational.
// Backpressure: none; it only observes words the loader has accepted.
//
// Ports: clk, rst_n (async active-low), clr_i (zero the sum), acc_i (fold
// data_i into the sum), data_i (stream word), match_o (data_i equals the sum).
module loader_checksum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  acc_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  match_o
);

    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (acc_i) begin
            sum_d = sum_q ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // The checksum word itself is never accumulated, so the sum still covers
    // exactly header + payload while it is being compared.
    assign match_o = (sum_q == data_i);

endmodule

// File: rtl/program_loader.sv
// program_loader: streams a header and IM/DM images from a valid/ready source into the processor RAMs.
// Latency: a word accepted at edge k drives the RAM pins from edge k; done rises one edge after the final word.
// Backpressure: in_ready depends only on state, so the source simply holds in_valid/in_data until taken.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   start                 begins a session from IDLE, DONE or ERROR; ignored otherwise
//   in_valid/in_data      upstream word stream, in_ready is the accept
//   loading               processor memory-source select, high for the whole session
//   im_*_load, dm_*_load  active-low CEN/WEN/OEN plus address and write data per RAM
//   done, error           session result levels
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum word
// (header ^ all payload words) that must match before the session completes.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     loading,
    output logic                     im_cen_load,
    output logic                     im_wen_load,
    output logic                     im_oen_load,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load,
    output logic [DATA_WIDTH-1:0]    im_datain_load,
    output logic                     dm_cen_load,
    output logic                     dm_wen_load,
    output logic                     dm_oen_load,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
    output logic [DATA_WIDTH-1:0]    dm_datain_load,
    output logic                     done,
    output logic                     error
);

    state_e state_q, state_d;

    // Words written so far in the current image; doubles as the RAM address.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Image sizes latched from the header.
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] m_q, m_d;

    // Registered RAM pins. CEN and WEN always move together for a write,
    // so one flop per RAM drives both.
    logic                     im_cen_q, im_cen_d;
    logic [ADDRESS_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [DATA_WIDTH-1:0]    im_data_q, im_data_d;
    logic                     dm_cen_q, dm_cen_d;
    logic [ADDRESS_WIDTH-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_WIDTH-1:0]    dm_data_q, dm_data_d;

    logic             accept;
    logic             session_start;
    logic [CNT_W-1:0] hdr_n;
    logic [CNT_W-1:0] hdr_m;
    logic             last_im;
    logic             last_dm;

    assign in_ready = (state_q == ST_HEADER)  ||
                      (state_q == ST_LOAD_IM) ||
                      (state_q == ST_LOAD_DM) ||
                      (state_q == ST_CHECK);

    assign accept        = in_valid && in_ready;
    assign session_start = start && ((state_q == ST_IDLE) ||
                                     (state_q == ST_DONE) ||
                                     (state_q == ST_ERROR));

    assign hdr_n = in_data[HDR_N_MSB:HDR_N_LSB];
    assign hdr_m = in_data[HDR_M_MSB:HDR_M_LSB];

    // The header rejects zero-length IM, so n_q - 1 cannot underflow while
    // loading; m_q == 0 never reaches LOAD_DM.
    assign last_im = (cnt_q == (n_q - CNT_W'(1)));
    assign last_dm = (cnt_q == (m_q - CNT_W'(1)));

`ifdef LOADER_CHECKSUM_EN
    logic csum_clr;
    logic csum_acc;
    logic csum_match;

    assign csum_clr = session_start;
    assign csum_acc = accept && (state_q != ST_CHECK);

    loader_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checksum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (csum_clr),
        .acc_i   (csum_acc),
        .data_i  (in_data),
        .match_o (csum_match)
    );

    // After the last payload word one more word (the checksum) is taken.
    localparam state_e TAIL_STATE = ST_CHECK;
`else
    localparam state_e TAIL_STATE = ST_FLUSH;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        m_d       = m_q;
        // Strobes drop back high on any cycle without an accepted payload
        // word; address and data hold so the RAM pins stay quiet.
        im_cen_d  = 1'b1;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;
        dm_cen_d  = 1'b1;
        dm_addr_d = dm_addr_q;
        dm_data_d = dm_data_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (session_start) begin
                    state_d = ST_HEADER;
                    cnt_d   = '0;
                end
            end

            ST_HEADER: begin
                if (accept) begin
                    n_d = hdr_n;
                    m_d = hdr_m;
                    if (hdr_bad(hdr_n, hdr_m)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD_IM;
                    end
                end
            end

            ST_LOAD_IM: begin
                if (accept) begin
                    im_cen_d  = 1'b0;
                    im_addr_d = ADDRESS_WIDTH'(cnt_q);
                    im_data_d = in_data;
                    if (last_im) begin
                        // DM addressing restarts at 0.
                        cnt_d   = '0;
                        state_d = (m_q == '0) ? TAIL_STATE : ST_LOAD_DM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_LOAD_DM: begin
                if (accept) begin
                    dm_cen_d  = 1'b0;
                    dm_addr_d = ADDRESS_WIDTH'(cnt_q);
                    dm_data_d = in_data;
                    if (last_dm) begin
                        cnt_d   = '0;
                        state_d = TAIL_STATE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_d = csum_match ? ST_FLUSH : ST_ERROR;
                end
            end
`endif

            // One idle cycle lets the RAM capture the final write while
            // loading still selects the loader as memory source.
            ST_FLUSH: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            m_q       <= '0;
            im_cen_q  <= 1'b1;
            im_addr_q <= '0;
            im_data_q <= '0;
            dm_cen_q  <= 1'b1;
            dm_addr_q <= '0;
            dm_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            m_q       <= m_d;
            im_cen_q  <= im_cen_d;
            im_addr_q <= im_addr_d;
            im_data_q <= im_data_d;
            dm_cen_q  <= dm_cen_d;
            dm_addr_q <= dm_addr_d;
            dm_data_q <= dm_data_d;
        end
    end

    // The loader never reads either RAM.
    assign im_cen_load    = im_cen_q;
    assign im_wen_load    = im_cen_q;
    assign im_oen_load    = 1'b1;
    assign im_addr_load   = im_addr_q;
    assign im_datain_load = im_data_q;

    assign dm_cen_load    = dm_cen_q;
    assign dm_wen_load    = dm_cen_q;
    assign dm_oen_load    = 1'b1;
    assign dm_addr_load   = dm_addr_q;
    assign dm_datain_load = dm_data_q;

    assign loading = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign done    = (state_q == ST_DONE);
    assign error   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed sessions against a behavioural loader model.
// Latency: model predicts every output one edge at a time; compared 1 time unit after each rising edge.
// Backpressure: source holds each word until in_valid && in_ready, with random or toggling valid.
module tb_program_loader;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int MAXW = 2048;

    localparam int P_IDLE  = 0;
    localparam int P_ACT   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;
    localparam int P_ERR   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, loading, done, error;
    logic          im_cen_load, im_wen_load, im_oen_load;
    logic          dm_cen_load, dm_wen_load, dm_oen_load;
    logic [AW-1:0] im_addr_load, dm_addr_load;
    logic [DW-1:0] im_datain_load, dm_datain_load;

    program_loader #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .loading        (loading),
        .im_cen_load    (im_cen_load),
        .im_wen_load    (im_wen_load),
        .im_oen_load    (im_oen_load),
        .im_addr_load   (im_addr_load),
        .im_datain_load (im_datain_load),
        .dm_cen_load    (dm_cen_load),
        .dm_wen_load    (dm_wen_load),
        .dm_oen_load    (dm_oen_load),
        .dm_addr_load   (dm_addr_load),
        .dm_datain_load (dm_datain_load),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A session is: one header word, then N IM words, then M DM words
    // (then one checksum word when enabled). Word j of the payload goes to
    // IM[j] if j < N, else DM[j-N].
    int            m_phase;
    int            m_idx;
    int            m_n;
    int            m_m;
    logic [DW-1:0] m_xor;
    logic          m_im_wr, m_dm_wr;
    logic [AW-1:0] m_im_addr, m_dm_addr;
    logic [DW-1:0] m_im_data, m_dm_data;

    task automatic model_accept(input logic [DW-1:0] word);
        int j;
        if (m_idx == 0) begin
            m_n   = int'(word[27:16]);
            m_m   = int'(word[11:0]);
            m_xor = word;
            if (m_n == 0 || m_n > MAXW || m_m > MAXW) m_phase = P_ERR;
            else m_idx = 1;
        end else begin
            j = m_idx - 1;
            if (j < m_n + m_m) begin
                if (j < m_n) begin
                    m_im_wr = 1'b1; m_im_addr = AW'(j); m_im_data = word;
                end else begin
                    m_dm_wr = 1'b1; m_dm_addr = AW'(j - m_n); m_dm_data = word;
                end
                m_xor = m_xor ^ word;
                m_idx++;
`ifndef LOADER_CHECKSUM_EN
                if (j + 1 == m_n + m_m) m_phase = P_FLUSH;
`endif
            end else begin
                m_phase = (word == m_xor) ? P_FLUSH : P_ERR;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_idx = 0; m_n = 0; m_m = 0; m_xor = '0;
            m_im_wr = 1'b0; m_dm_wr = 1'b0;
            m_im_addr = '0; m_dm_addr = '0; m_im_data = '0; m_dm_data = '0;
        end else begin
            m_im_wr = 1'b0;
            m_dm_wr = 1'b0;
            case (m_phase)
                P_IDLE, P_DONE, P_ERR: if (start) begin
                    m_phase = P_ACT; m_idx = 0; m_xor = '0;
                end
                P_FLUSH: m_phase = P_DONE;
                P_ACT:   if (in_valid) model_accept(in_data);
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("ctrl", {in_ready, loading, done, error},
                  {m_phase == P_ACT, (m_phase == P_ACT) || (m_phase == P_FLUSH),
                   m_phase == P_DONE, m_phase == P_ERR});
            check("im_bus", {im_cen_load, im_wen_load, im_oen_load, im_addr_load, im_datain_load},
                  {~m_im_wr, ~m_im_wr, 1'b1, m_im_addr, m_im_data});
            check("dm_bus", {dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load},
                  {~m_dm_wr, ~m_dm_wr, 1'b1, m_dm_addr, m_dm_data});
        end
    end

    // ---------------- RAM models capturing DUT writes ----------------
    logic [DW-1:0] im_ram [0:MAXW-1];
    logic [DW-1:0] dm_ram [0:MAXW-1];
    int            im_wr_cnt = 0;
    int            dm_wr_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && !im_cen_load && !im_wen_load) begin
            im_ram[im_addr_load] = im_datain_load;
            im_wr_cnt++;
        end
        if (rst_n && !dm_cen_load && !dm_wen_load) begin
            dm_ram[dm_addr_load] = dm_datain_load;
            dm_wr_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {in_ready, loading, done, error}, 64'h0);
        check({tag, "_im"}, {im_cen_load, im_wen_load, im_oen_load, im_addr_load, im_datain_load},
              {3'b111, 43'd0});
        check({tag, "_dm"}, {dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load},
              {3'b111, 43'd0});
    endtask

    // One full session. vprob < 0 means in_valid toggles 1,0,1,0...
    // edges = rising edges from the one taking start to the one raising done/error.
    task automatic run_session(input int n, input int m, input int vprob, input bit rnd_start,
                               input bit corrupt, input bit fixed_data, output int edges);
        logic [DW-1:0] words[$];
        logic [DW-1:0] exp_im[$];
        logic [DW-1:0] exp_dm[$];
        logic [DW-1:0] w, hdr, x;
        logic [1:0]    exp_end;
        bit            bad, v, acc, tog;
        int            waits, budget;

        bad = (n == 0) || (n > MAXW) || (m > MAXW);
        hdr = $urandom();
        hdr[27:16] = n[11:0];
        hdr[11:0]  = m[11:0];
        words.push_back(hdr);
        x = hdr;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                w = fixed_data ? (32'hA000_0000 | 32'(i)) : $urandom();
                exp_im.push_back(w); words.push_back(w); x = x ^ w;
            end
            for (int i = 0; i < m; i++) begin
                w = fixed_data ? (32'hB000_0000 | 32'(i)) : $urandom();
                exp_dm.push_back(w); words.push_back(w); x = x ^ w;
            end
        end
        exp_end = bad ? 2'b01 : 2'b10;
`ifdef LOADER_CHECKSUM_EN
        if (!bad) begin
            words.push_back(corrupt ? (x ^ 32'h0000_0100) : x);
            if (corrupt) exp_end = 2'b01;
        end
`endif

        for (int i = 0; i < MAXW; i++) begin
            im_ram[i] = '0;
            dm_ram[i] = '0;
        end
        im_wr_cnt = 0;
        dm_wr_cnt = 0;

        waits = 0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk); waits++;
        start = 1'b0;
        tog = 1'b1;
        budget = 0;
        while (words.size() > 0 && budget < 20000) begin
            v = (vprob < 0) ? tog : (int'($urandom_range(99)) < vprob);
            tog = ~tog;
            in_valid = v;
            in_data  = v ? words[0] : $urandom();
            start    = rnd_start && ($urandom_range(7) == 0);
            acc      = v && in_ready;
            @(negedge clk); waits++; budget++;
            if (acc) void'(words.pop_front());
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("stream_drained", words.size(), 0);

        budget = 0;
        while (!(done || error) && budget < 20) begin
            @(negedge clk); waits++; budget++;
        end
        edges = waits - 1;
        check("end_state", {done, error}, exp_end);

        if (bad) begin
            check("no_writes", im_wr_cnt + dm_wr_cnt, 0);
        end else begin
            check("im_count", im_wr_cnt, n);
            check("dm_count", dm_wr_cnt, m);
            for (int i = 0; i < n; i++) check("im_ram", im_ram[i], exp_im[i]);
            for (int i = 0; i < m; i++) check("dm_ram", dm_ram[i], exp_dm[i]);
        end
    endtask

    initial begin
        int  e, n, m, sel, vp;
        logic [DW-1:0] hdr5;

        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // N=3, M=2, valid held high: done 7 edges after start.
        run_session(3, 2, 100, 1'b0, 1'b0, 1'b1, e);
        check("done_latency", e, 7);
        check("im0", im_ram[0], 32'hA000_0000);
        check("im1", im_ram[1], 32'hA000_0001);
        check("im2", im_ram[2], 32'hA000_0002);
        check("dm0", dm_ram[0], 32'hB000_0000);
        check("dm1", dm_ram[1], 32'hB000_0001);
        check("loading_at_done", {loading, done}, 2'b01);

        // IM only.
        run_session(2, 0, 100, 1'b0, 1'b0, 1'b1, e);
        check("dm_untouched", dm_wr_cnt, 0);
        check("im_only_done", {done, error}, 2'b10);

        // Bad headers.
        run_session(0, 5, 100, 1'b0, 1'b0, 1'b1, e);
        check("n0_error", {loading, done, error}, 3'b001);
        check("n0_writes", im_wr_cnt + dm_wr_cnt, 0);
        run_session(1, 2049, 100, 1'b0, 1'b0, 1'b1, e);
        check("m801_error", {loading, done, error}, 3'b001);
        run_session(2049, 0, 100, 1'b0, 1'b0, 1'b1, e);
        check("n801_error", error, 1'b1);

        // Valid toggling 1,0,1,0 during IM load.
        run_session(4, 1, -1, 1'b0, 1'b0, 1'b1, e);
        check("toggle_im_count", im_wr_cnt, 4);

        // Reset after 2 of 5 IM words.
        hdr5 = 32'h0005_0000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = hdr5;
        @(negedge clk); in_data = 32'hC000_0000;
        @(negedge clk); in_data = 32'hC000_0001;
        @(negedge clk);
        check("pre_reset_write", {im_cen_load, im_addr_load, im_datain_load}, {1'b0, 11'd1, 32'hC000_0001});
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_session(5, 0, 100, 1'b0, 1'b0, 1'b1, e);
        check("reload_addr0", im_ram[0], 32'hA000_0000);

`ifdef LOADER_CHECKSUM_EN
        run_session(3, 2, 100, 1'b0, 1'b1, 1'b1, e);
        check("csum_bad", {done, error}, 2'b01);
        run_session(3, 2, 100, 1'b0, 1'b0, 1'b1, e);
        check("csum_good", {done, error}, 2'b10);
`endif

        // Randomized sessions with random backpressure and ignored starts.
        for (int s = 0; s < 40; s++) begin
            sel = int'($urandom_range(7));
            n   = int'($urandom_range(1, 24));
            m   = int'($urandom_range(0, 12));
            if (sel == 0) n = 0;
            if (sel == 1) m = int'($urandom_range(2049, 4095));
            if (sel == 2) n = int'($urandom_range(2049, 4095));
            vp  = int'($urandom_range(30, 100));
            run_session(n, m, vp, 1'b1, bit'($urandom_range(1)), 1'b0, e);
        end

        // Both images at full depth.
        run_session(MAXW, MAXW, 100, 1'b0, 1'b0, 1'b0, e);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 11, SHALL set the memory word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the memory data width and stream word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL begin a load session when high in IDLE, DONE or ERROR.
REQ-006 in_valid / in_data  input  1 / DATA_WIDTH  SHALL carry the upstream word stream.
REQ-007 in_ready  output  1  SHALL indicate that the loader accepts a word this cycle.
REQ-008 loading  output  1  SHALL drive the processor's memory-source select.
REQ-009 im_cen_load, im_wen_load, im_oen_load  output  1 each  SHALL be active-low instruction-RAM strobes.
REQ-010 im_addr_load / im_datain_load  output  ADDRESS_WIDTH / DATA_WIDTH  SHALL be the instruction-RAM address and write data.
REQ-011 dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load  SHALL mirror REQ-009/010 for the data RAM.
REQ-012 done / error  output  1 / 1  SHALL report session success or failure as levels.

Function
REQ-013 States SHALL be IDLE, HEADER, LOAD_IM, LOAD_DM, FLUSH, DONE and ERROR.
REQ-014 in_ready SHALL be 1 only in HEADER, LOAD_IM and LOAD_DM; a word is accepted when in_valid && in_ready.
REQ-015 Header word: bits[27:16] = IM count N, bits[11:0] = DM count M; N==0, N>2048 or M>2048 SHALL go to ERROR.
REQ-016 After HEADER, exactly N words SHALL be written to IM addresses 0..N-1, then M words to DM addresses 0..M-1; M==0 skips LOAD_DM.
REQ-017 All memory outputs SHALL be registered: a word accepted at edge k is presented from edge k with CEN=0, WEN=0, OEN=1; the RAM captures it at edge k+1.
REQ-018 In any cycle without an accepted word, all six strobes SHALL be 1; address and data hold their last values.
REQ-019 The address counter SHALL increment only on acceptance and reset to 0 when switching IM to DM; it SHALL never wrap (bounded by REQ-015).
REQ-020 After the last accepted word the FSM SHALL enter FLUSH for one cycle so the final write completes, then DONE.
REQ-021 loading SHALL be 1 from the edge leaving IDLE/DONE/ERROR on start until the edge entering DONE or ERROR.
REQ-022 done SHALL be 1 only in DONE and error only in ERROR; both clear on the edge that accepts start.
REQ-023 start SHALL be ignored in HEADER, LOAD_IM, LOAD_DM and FLUSH.

Reset
REQ-024 On rst_n low, immediately: state IDLE, loading=0, in_ready=0, done=0, error=0, all strobes 1, addresses and data 0, counters 0.
REQ-025 Reset mid-session SHALL abandon the session; no partial write strobe SHALL remain asserted.

Configuration
REQ-026 With LOADER_CHECKSUM_EN defined, one extra stream word SHALL follow the payload; if it differs from the XOR of header and all payload words, the FSM enters ERROR, otherwise FLUSH.
REQ-027 Without LOADER_CHECKSUM_EN, no checksum word SHALL be expected and the last payload word leads directly to FLUSH.

Structure
REQ-028 Package loader_pkg SHALL hold the state enum, header field bit positions, and MAX_WORDS = 2048.
REQ-029 Sub-module loader_checksum (running XOR accumulator, clear/accumulate/compare) SHALL be instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-030 Header N=3, M=2, data A0..A2, B0..B1, in_valid always 1 -> IM[0..2]=A0..A2, DM[0..1]=B0..B1; done rises 7 edges after start; loading low one cycle after the last strobe.
REQ-031 Header N=2, M=0 -> only IM written, DM strobes never asserted, done=1.
REQ-032 Header N=0 or M=0x801 -> error=1, loading=0, no strobe ever 0.
REQ-033 in_valid toggled 1,0,1,0 during LOAD_IM -> one write per accepted word, addresses contiguous, strobes high in gap cycles.
REQ-034 rst_n pulsed low after 2 of 5 IM words -> immediate IDLE state, all outputs at reset values; a new start reloads from address 0.
REQ-035 With LOADER_CHECKSUM_EN, corrupted checksum word -> error=1; correct checksum word -> done=1.
